// File: rtl/aes_128_inv_iter_if.sv
// Handshake bundle for the iterative AES-128 decryption core.
//   in_valid/in_ready : ciphertext + key acceptance (master drives in_valid, ct, key)
//   ct, key           : 128-bit ciphertext and key, byte 0 = [127:120]
//   out_valid/out_ready : plaintext delivery (master drives out_ready)
//   pt                : 128-bit plaintext
//   busy              : core is working on or holding a block
interface aes_128_inv_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic         busy;

  modport master (output in_valid, ct, key, out_ready,
                  input  in_ready, out_valid, pt, busy);
  modport slave  (input  in_valid, ct, key, out_ready,
                  output in_ready, out_valid, pt, busy);
endinterface

// File: rtl/aes_128_inv_iter.sv
// Iterative AES-128 decryption core. Forward-expands the cipher key to the
// round-10 key (skipped when KEY_IS_RK10=1), then runs ten inverse rounds,
// unwinding the round key one step per round so no schedule is stored.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of aes_128_inv_iter_if (input/output handshakes, busy)
module aes_128_inv_iter #(
  parameter bit KEY_IS_RK10 = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  aes_128_inv_iter_if.slave bus
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(9);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ARK, S_ROUND, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   st_q, st_d;
  logic [BLK_W-1:0]   rk_q, rk_d;
  logic [BLK_W-1:0]   pt_q, pt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  // GF(2^8) multiply by x modulo 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (254 = 0b1111_1110); maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // S-boxes are computed (inverse + affine) rather than tabulated
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    logic [7:0] s;
    b = gf_inv(a);
    for (int i = 0; i < 8; i++)
      s[3'(i)] = b[3'(i)] ^ b[3'(i+4)] ^ b[3'(i+5)] ^ b[3'(i+6)] ^ b[3'(i+7)];
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[3'(i)] = a[3'(i+2)] ^ a[3'(i+5)] ^ a[3'(i+7)];
    return gf_inv(b ^ 8'h05);
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte (row r, column c) sits at index 4c+r; row r rotates right by r
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  // Multiply by a constant whose bits select x^0..x^3 (0e, 0b, 0d, 09 only need these)
  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9);
      o[119-32*c -: 8] = mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd);
      o[111-32*c -: 8] = mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb);
      o[103-32*c -: 8] = mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he);
    end
    return o;
  endfunction

  // Shared key datapath: forward expansion step and inverse unwind step
  logic [WORD_W-1:0] w0, w1, w2, w3, sw_in, t;
  logic [BLK_W-1:0]  rk_fwd, rk_prev, st_rnd;

  always_comb begin
    w0      = rk_q[127:96];
    w1      = rk_q[95:64];
    w2      = rk_q[63:32];
    w3      = rk_q[31:0];
    // The four forward S-boxes see w3 when expanding, prev.w3 = w3^w2 when unwinding
    sw_in   = (state_q == S_KEXP) ? w3 : (w3 ^ w2);
    t       = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon_q, 24'h000000};
    rk_fwd  = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
    rk_prev = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    st_rnd  = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_prev;
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    pt_d        = pt_q;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          st_d    = bus.ct;
          rk_d    = bus.key;
          cnt_d   = '0;
          rcon_d  = 8'h01;
          state_d = KEY_IS_RK10 ? S_ARK : S_KEXP;
        end
      end
      S_KEXP: begin
        rk_d   = rk_fwd;
        rcon_d = xtime(rcon_q);
        if (cnt_q == LAST_STEP) state_d = S_ARK;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ARK: begin
        st_d    = st_q ^ rk_q;
        cnt_d   = LAST_STEP;
        rcon_d  = 8'h36;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        rk_d   = rk_prev;
        // Walk the rcon sequence backwards: 36, 1b, 80, 40, ... 01
        rcon_d = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};
        if (cnt_q == '0) begin
          st_d        = st_rnd;
          pt_d        = st_rnd;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          st_d  = inv_mix_columns(st_rnd);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      pt_q        <= '0;
      cnt_q       <= '0;
      rcon_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      pt_q        <= pt_d;
      cnt_q       <= cnt_d;
      rcon_q      <= rcon_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pt        = pt_q;
  assign bus.busy      = busy_q;

endmodule
